// File: rtl/mem_bus_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single memory bus port.
// One transaction outstanding; round-robin or D-priority on contention.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter bit FIXED_PRIO_D = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_req_wen,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  i_resp_valid,
  output logic [DATA_WIDTH-1:0] i_resp_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_wen,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_resp_valid,
  output logic [DATA_WIDTH-1:0] d_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t state;
  req_t   req_q;
  logic   owner;       // 0 = I-cache, 1 = D-cache
  logic   last_grant;  // same encoding as owner
  logic   pick_i, pick_d, idle, resp_hit;

  // D wins when alone, under fixed priority, or when I was served last.
  assign pick_d = d_req_valid & (~i_req_valid | FIXED_PRIO_D | ~last_grant);
  assign pick_i = i_req_valid & ~pick_d;

  // rst_n gate keeps the combinational readies low while reset is held.
  assign idle        = (state == IDLE) & rst_n;
  assign i_req_ready = idle & pick_i;
  assign d_req_ready = idle & pick_d;

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wen   = req_q.wen;
  assign mem_req_wdata = req_q.wdata;
  assign busy          = (state != IDLE);

  assign resp_hit     = (state == WAIT) & mem_resp_valid;
  assign i_resp_valid = resp_hit & ~owner;
  assign d_resp_valid = resp_hit & owner;
  assign i_resp_rdata = i_resp_valid ? mem_resp_rdata : '0;
  assign d_resp_rdata = d_resp_valid ? mem_resp_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick_i | pick_d) begin
            req_q      <= pick_d ? '{d_req_addr, d_req_wen, d_req_wdata}
                                 : '{i_req_addr, i_req_wen, i_req_wdata};
            owner      <= pick_d;
            last_grant <= pick_d;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Writes retire at bus acceptance; reads wait for data.
          if (mem_req_ready) state <= req_q.wen ? IDLE : WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (round-robin and D-priority),
// a transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv[2], iw[2], dv[2], dw[2], mrdy[2], mrv[2];
  logic [31:0] ia[2], iwd[2], da[2], dwd[2], mrd[2];
  logic        irdy[2], drdy[2], irv[2], drv[2], mv[2], mw[2], bz[2];
  logic [31:0] ird[2], drd[2], ma[2], mwd[2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bus_auto[2];
  req_t iq[2][$];
  req_t dq[2][$];

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO_D(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(iv[0]), .i_req_ready(irdy[0]), .i_req_addr(ia[0]), .i_req_wen(iw[0]),
    .i_req_wdata(iwd[0]), .i_resp_valid(irv[0]), .i_resp_rdata(ird[0]),
    .d_req_valid(dv[0]), .d_req_ready(drdy[0]), .d_req_addr(da[0]), .d_req_wen(dw[0]),
    .d_req_wdata(dwd[0]), .d_resp_valid(drv[0]), .d_resp_rdata(drd[0]),
    .mem_req_valid(mv[0]), .mem_req_ready(mrdy[0]), .mem_req_addr(ma[0]),
    .mem_req_wen(mw[0]), .mem_req_wdata(mwd[0]), .mem_resp_valid(mrv[0]),
    .mem_resp_rdata(mrd[0]), .busy(bz[0]));

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO_D(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(iv[1]), .i_req_ready(irdy[1]), .i_req_addr(ia[1]), .i_req_wen(iw[1]),
    .i_req_wdata(iwd[1]), .i_resp_valid(irv[1]), .i_resp_rdata(ird[1]),
    .d_req_valid(dv[1]), .d_req_ready(drdy[1]), .d_req_addr(da[1]), .d_req_wen(dw[1]),
    .d_req_wdata(dwd[1]), .d_resp_valid(drv[1]), .d_resp_rdata(drd[1]),
    .mem_req_valid(mv[1]), .mem_req_ready(mrdy[1]), .mem_req_addr(ma[1]),
    .mem_req_wen(mw[1]), .mem_req_wdata(mwd[1]), .mem_resp_valid(mrv[1]),
    .mem_resp_rdata(mrd[1]), .busy(bz[1]));

  task automatic chk1(input string nm, input int p, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b expected %b (cycle %0d)", nm, p, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h (cycle %0d)", nm, p, act, exp, cyc);
    end
  endtask

  // Transaction-level model: is a transaction open, has the bus taken it, who owns it.
  bit          m_busy[2], m_acc[2], m_owner[2], m_last[2], m_wen[2];
  logic [31:0] m_addr[2], m_wdata[2];

  function automatic int winner(input int p);
    if (m_busy[p]) return -1;
    if (iv[p] && dv[p]) return (p == 1) ? 1 : (m_last[p] ? 0 : 1);
    if (iv[p]) return 0;
    if (dv[p]) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int p = 0; p < 2; p++) begin
      int w;
      if (!rst_n) begin
        m_busy[p] <= 1'b0; m_acc[p] <= 1'b0; m_owner[p] <= 1'b0; m_last[p] <= 1'b1;
        m_addr[p] <= '0; m_wen[p] <= 1'b0; m_wdata[p] <= '0;
      end else begin
        w = winner(p);
        if (w >= 0) begin
          m_busy[p]  <= 1'b1; m_acc[p] <= 1'b0;
          m_owner[p] <= (w == 1); m_last[p] <= (w == 1);
          m_addr[p]  <= (w == 1) ? da[p] : ia[p];
          m_wen[p]   <= (w == 1) ? dw[p] : iw[p];
          m_wdata[p] <= (w == 1) ? dwd[p] : iwd[p];
        end else if (m_busy[p] && !m_acc[p] && mrdy[p]) begin
          if (m_wen[p]) m_busy[p] <= 1'b0;
          else          m_acc[p]  <= 1'b1;
        end else if (m_busy[p] && m_acc[p] && mrv[p]) begin
          m_busy[p] <= 1'b0; m_acc[p] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      int   w;
      logic rv, ie, de;
      w  = rst_n ? winner(p) : -1;
      rv = m_busy[p] && m_acc[p] && mrv[p];
      ie = rv && !m_owner[p];
      de = rv && m_owner[p];
      chk1("i_req_ready", p, irdy[p], w == 0);
      chk1("d_req_ready", p, drdy[p], w == 1);
      chk1("mem_req_valid", p, mv[p], m_busy[p] && !m_acc[p]);
      chk1("busy", p, bz[p], m_busy[p]);
      chk1("i_resp_valid", p, irv[p], ie);
      chk1("d_resp_valid", p, drv[p], de);
      chk32("i_resp_rdata", p, ird[p], ie ? mrd[p] : 32'h0);
      chk32("d_resp_rdata", p, drd[p], de ? mrd[p] : 32'h0);
      if (m_busy[p] && !m_acc[p]) begin
        chk32("mem_req_addr", p, ma[p], m_addr[p]);
        chk1("mem_req_wen", p, mw[p], m_wen[p]);
        chk32("mem_req_wdata", p, mwd[p], m_wdata[p]);
      end
    end
  end

  // One clock: capture accepts at negedge, then update requesters/bus at posedge+1.
  task automatic tick();
    bit ai[2], ad[2];
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin ai[p] = irdy[p]; ad[p] = drdy[p]; end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      req_t r;
      if (iv[p] && ai[p]) iv[p] = 1'b0;
      if (dv[p] && ad[p]) dv[p] = 1'b0;
      if (!iv[p] && iq[p].size() > 0) begin
        r = iq[p].pop_front();
        iv[p] = 1'b1; ia[p] = r.addr; iw[p] = r.wen; iwd[p] = r.wdata;
      end
      if (!dv[p] && dq[p].size() > 0) begin
        r = dq[p].pop_front();
        dv[p] = 1'b1; da[p] = r.addr; dw[p] = r.wen; dwd[p] = r.wdata;
      end
      if (bus_auto[p]) begin
        mrdy[p] = 1'b1; mrv[p] = 1'b1; mrd[p] = 32'hA000_0000 | 32'(cyc);
      end
    end
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d;
    return r;
  endfunction

  logic [3:0] c_rdy[6];
  logic [3:0] c_rv[6];

  initial begin
    for (int p = 0; p < 2; p++) begin
      iv[p] = 0; iw[p] = 0; dv[p] = 0; dw[p] = 0; mrdy[p] = 0; mrv[p] = 0;
      ia[p] = 0; iwd[p] = 0; da[p] = 0; dwd[p] = 0; mrd[p] = 0; bus_auto[p] = 0;
    end
    // Reset: ready must stay low even with requests pending.
    iv[0] = 1; dv[1] = 1;
    #12;
    chk1("rst_i_ready", 0, irdy[0], 1'b0);
    chk1("rst_d_ready", 1, drdy[1], 1'b0);
    chk1("rst_busy", 0, bz[0], 1'b0);
    chk1("rst_mem_valid", 0, mv[0], 1'b0);
    chk32("rst_addr", 0, ma[0], 32'h0);
    chk1("rst_wen", 1, mw[1], 1'b0);
    iv[0] = 0; dv[1] = 0;
    @(posedge clk); #1 rst_n = 1;
    tick(); tick();

    // Single D read, manual bus.
    dq[0].push_back(mk(32'h100, 1'b0, 32'h0));
    tick(); #3;
    chk1("b_d_ready", 0, drdy[0], 1'b1);
    chk1("b_i_ready", 0, irdy[0], 1'b0);
    tick(); mrdy[0] = 1; #3;
    chk1("b_mem_valid", 0, mv[0], 1'b1);
    chk32("b_mem_addr", 0, ma[0], 32'h100);
    chk1("b_mem_wen", 0, mw[0], 1'b0);
    chk1("b_d_ready2", 0, drdy[0], 1'b0);
    tick(); mrdy[0] = 0; mrv[0] = 1; mrd[0] = 32'hDEAD_BEEF; #3;
    chk1("b_d_resp", 0, drv[0], 1'b1);
    chk32("b_d_rdata", 0, drd[0], 32'hDEAD_BEEF);
    chk1("b_i_resp", 0, irv[0], 1'b0);
    tick(); mrv[0] = 0; #3;
    chk1("b_d_resp_end", 0, drv[0], 1'b0);
    chk1("b_busy_end", 0, bz[0], 1'b0);

    // Simultaneous I read / D write from reset, both arbitration modes.
    tick();
    rst_n = 0; #2 rst_n = 1;
    for (int p = 0; p < 2; p++) begin
      iq[p].push_back(mk(32'h0, 1'b0, 32'h0));
      dq[p].push_back(mk(32'h200, 1'b1, 32'h1234_5678));
      bus_auto[p] = 1;
    end
    c_rdy = '{4'b1001, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    c_rv  = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
    for (int t = 0; t < 6; t++) begin
      tick(); #3;
      chk1("c_i_ready", 0, irdy[0], c_rdy[t][3]);
      chk1("c_d_ready", 0, drdy[0], c_rdy[t][2]);
      chk1("c_i_ready", 1, irdy[1], c_rdy[t][1]);
      chk1("c_d_ready", 1, drdy[1], c_rdy[t][0]);
      chk1("c_i_resp", 0, irv[0], c_rv[t][3]);
      chk1("c_d_resp", 0, drv[0], c_rv[t][2]);
      chk1("c_i_resp", 1, irv[1], c_rv[t][1]);
      chk1("c_d_resp", 1, drv[1], c_rv[t][0]);
      if (t == 1) begin
        chk32("c_wr_addr", 1, ma[1], 32'h200);
        chk1("c_wr_wen", 1, mw[1], 1'b1);
        chk32("c_wr_data", 1, mwd[1], 32'h1234_5678);
      end
      if (t == 2) chk32("c_i_rdata", 0, ird[0], 32'hA000_0000 | 32'(cyc));
      if (t == 4) begin
        chk32("c_wr_addr", 0, ma[0], 32'h200);
        chk1("c_wr_wen", 0, mw[0], 1'b1);
        chk32("c_wr_data", 0, mwd[0], 32'h1234_5678);
      end
    end

    // Backpressure with contention; spurious response while in ISSUE.
    tick();
    bus_auto[0] = 0; mrdy[0] = 0; mrv[0] = 0;
    iq[0].push_back(mk(32'h300, 1'b0, 32'h0));
    iq[0].push_back(mk(32'h400, 1'b0, 32'h0));
    dq[0].push_back(mk(32'h500, 1'b1, 32'h55));
    tick(); #3;
    chk1("d_i_ready", 0, irdy[0], 1'b1);
    chk1("d_d_ready", 0, drdy[0], 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(); mrv[0] = (k == 2); #3;
      chk1("d_hold_valid", 0, mv[0], 1'b1);
      chk32("d_hold_addr", 0, ma[0], 32'h300);
      chk1("d_no_i_ready", 0, irdy[0], 1'b0);
      chk1("d_no_d_ready", 0, drdy[0], 1'b0);
      chk1("d_no_resp", 0, irv[0], 1'b0);
    end
    tick(); mrv[0] = 0; mrdy[0] = 1; #3;
    chk1("d_issue", 0, mv[0], 1'b1);
    tick(); mrdy[0] = 0; mrv[0] = 1; mrd[0] = 32'hCAFE_0001; #3;
    chk1("d_i_resp", 0, irv[0], 1'b1);
    chk32("d_i_rdata", 0, ird[0], 32'hCAFE_0001);
    tick(); mrv[0] = 0; #3;
    chk1("d_alt_d_ready", 0, drdy[0], 1'b1);
    chk1("d_alt_i_ready", 0, irdy[0], 1'b0);
    bus_auto[0] = 1;
    repeat (8) tick();

    // Reset asserted while a read is in WAIT.
    bus_auto[0] = 0; mrdy[0] = 0; mrv[0] = 0;
    iq[0].push_back(mk(32'h600, 1'b0, 32'h0));
    tick(); #3;
    chk1("e_i_ready", 0, irdy[0], 1'b1);
    tick(); mrdy[0] = 1;
    tick(); mrdy[0] = 0;
    #1;
    chk1("e_wait_busy", 0, bz[0], 1'b1);
    chk1("e_wait_valid", 0, mv[0], 1'b0);
    #1 rst_n = 0; mrv[0] = 1;
    #1;
    chk1("e_rst_busy", 0, bz[0], 1'b0);
    chk1("e_rst_mem_valid", 0, mv[0], 1'b0);
    chk1("e_rst_i_resp", 0, irv[0], 1'b0);
    chk32("e_rst_i_rdata", 0, ird[0], 32'h0);
    for (int p = 0; p < 2; p++) begin
      iq[p].push_back(mk(32'h700, 1'b0, 32'h0));
      dq[p].push_back(mk(32'h800, 1'b0, 32'h0));
    end
    tick();
    mrv[0] = 0; rst_n = 1; #3;
    chk1("e_post_i_ready", 0, irdy[0], 1'b1);
    chk1("e_post_d_ready", 0, drdy[0], 1'b0);
    chk1("e_post_d_ready", 1, drdy[1], 1'b1);
    chk1("e_post_i_ready", 1, irdy[1], 1'b0);
    bus_auto[0] = 1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
